// File: rtl/sha_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padder.
package sha_pkg;
  localparam int         BLOCK_W     = 512;
  localparam int         LEN_FIELD_W = 64;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/pad_block_gen.sv
// Combinational generator of one 512-bit padded block from a captured message,
// its byte length and the block index (messages span at most two blocks).
module pad_block_gen
  import sha_pkg::*;
#(
  parameter int MAX_BYTES = 80,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic [MAX_BYTES*8-1:0] msg,
  input  logic [CNT_W-1:0]       len,
  input  logic                   blk,
  output logic [BLOCK_W-1:0]     block,
  output logic                   last
);

  logic [7:0]             msg_bytes [0:127];
  logic [7:0]             len8_s;
  logic [7:0]             last_idx_s;
  logic [7:0]             g_s;
  logic [LEN_FIELD_W-1:0] len_bits_s;
  logic                   last_s;
  logic [BLOCK_W-1:0]     block_s;

  // Unpack the big-endian message into a zero-extended 128-entry byte table.
  genvar k;
  generate
    for (k = 0; k < 128; k++) begin : g_bytes
      if (k < MAX_BYTES) begin : g_msg
        assign msg_bytes[k] = msg[MAX_BYTES*8-1-8*k -: 8];
      end else begin : g_zero
        assign msg_bytes[k] = 8'h00;
      end
    end
  endgenerate

  // Byte-wise selection: message, pad marker, length field or zero.
  always_comb begin
    len8_s     = 8'(len);
    last_idx_s = (len8_s + 8'd8) >> 6;
    last_s     = (blk == last_idx_s[0]);
    len_bits_s = LEN_FIELD_W'(len) << 3;
    block_s    = '0;
    g_s        = 8'd0;
    for (int j = 0; j < 64; j++) begin
      g_s = {1'b0, blk, j[5:0]};
      if (g_s < len8_s) begin
        block_s[BLOCK_W-1-8*j -: 8] = msg_bytes[g_s[6:0]];
      end else if (g_s == len8_s) begin
        block_s[BLOCK_W-1-8*j -: 8] = PAD_BYTE;
      end else if (last_s && (j >= 56)) begin
        block_s[BLOCK_W-1-8*j -: 8] = len_bits_s[8*(63-j) +: 8];
      end else begin
        block_s[BLOCK_W-1-8*j -: 8] = 8'h00;
      end
    end
  end

  assign block = block_s;
  assign last  = last_s;

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: captures a message, then streams its padded
// 512-bit blocks over a valid/ready handshake.
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int MAX_BYTES = 80,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [MAX_BYTES*8-1:0] inputMsg,
  input  logic [CNT_W-1:0]       msg_len,
  input  logic                   beginPreprocess,
  output logic [BLOCK_W-1:0]     processedMsg,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic                   last_block,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_r, state_s;
  logic [MAX_BYTES*8-1:0] msg_r, msg_s;
  logic [CNT_W-1:0]       len_r, len_s;
  logic                   blk_r, blk_s;
  logic [BLOCK_W-1:0]     block_r, block_s;
  logic                   valid_r, valid_s;
  logic                   last_r, last_s;
  logic                   busy_r, busy_s;
  logic                   done_r, done_s;

  logic [CNT_W-1:0]       len_sat_s;
  logic                   gen_blk_s;
  logic [BLOCK_W-1:0]     gen_block_s;
  logic                   gen_last_s;

  assign len_sat_s = (msg_len > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : msg_len;
  // In EMIT the generator looks one block ahead so the next block is ready at the handshake.
  assign gen_blk_s = (state_r == EMIT) ? ~blk_r : 1'b0;

  pad_block_gen #(
    .MAX_BYTES(MAX_BYTES),
    .CNT_W    (CNT_W)
  ) u_gen (
    .msg  (msg_r),
    .len  (len_r),
    .blk  (gen_blk_s),
    .block(gen_block_s),
    .last (gen_last_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    msg_s   = msg_r;
    len_s   = len_r;
    blk_s   = blk_r;
    block_s = block_r;
    valid_s = valid_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (beginPreprocess) begin
          msg_s   = inputMsg;
          len_s   = len_sat_s;
          blk_s   = 1'b0;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        block_s = gen_block_s;
        valid_s = 1'b1;
        last_s  = gen_last_s;
        state_s = EMIT;
      end
      EMIT: begin
        if (valid_r && block_ready) begin
          if (last_r) begin
            valid_s = 1'b0;
            last_s  = 1'b0;
            state_s = DONE;
          end else begin
            blk_s   = gen_blk_s;
            block_s = gen_block_s;
            last_s  = gen_last_s;
          end
        end else begin
          state_s = EMIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    done_s = (state_s == DONE);
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r <= IDLE;
      msg_r   <= '0;
      len_r   <= '0;
      blk_r   <= 1'b0;
      block_r <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      msg_r   <= msg_s;
      len_r   <= len_s;
      blk_r   <= blk_s;
      block_r <= block_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign processedMsg = block_r;
  assign block_valid  = valid_r;
  assign last_block   = last_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Self-checking bench: directed corner lengths plus random messages compared
// against a byte-array padding model.
module tb_sha_msg_padder;
  localparam int MB = 80;
  localparam int CW = $clog2(MB + 1);

  logic            clk;
  logic            n_rst;
  logic [MB*8-1:0] inputMsg;
  logic [CW-1:0]   msg_len;
  logic            beginPreprocess;
  logic [511:0]    processedMsg;
  logic            block_valid;
  logic            block_ready;
  logic            last_block;
  logic            busy;
  logic            done;

  int n_tests;
  int n_fail;

  logic [7:0]   msg_b [0:127];
  logic [511:0] exp_q [$];

  sha_msg_padder #(.MAX_BYTES(MB)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .inputMsg       (inputMsg),
    .msg_len        (msg_len),
    .beginPreprocess(beginPreprocess),
    .processedMsg   (processedMsg),
    .block_valid    (block_valid),
    .block_ready    (block_ready),
    .last_block     (last_block),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Padding model: message bytes, 0x80, zero fill, 64-bit bit-length at the end.
  task automatic build_expected(input int len);
    logic [7:0]  pad [0:255];
    logic [63:0] bits;
    logic [511:0] blk;
    int nblk;
    nblk = (len + 8) / 64 + 1;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 256; i++) begin
      if (i < len) pad[i] = msg_b[i];
      else if (i == len) pad[i] = 8'h80;
      else pad[i] = 8'h00;
    end
    for (int k = 0; k < 8; k++) pad[nblk*64-1-k] = bits[8*k +: 8];
    exp_q.delete();
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*b+j];
      exp_q.push_back(blk);
    end
  endtask

  task automatic pack_msg();
    for (int i = 0; i < MB; i++) inputMsg[MB*8-1-8*i -: 8] = msg_b[i];
  endtask

  task automatic scramble_inputs();
    for (int w = 0; w < MB / 4; w++) inputMsg[32*w +: 32] = $urandom;
    msg_len = CW'($urandom_range(0, 127));
  endtask

  task automatic fill_msg(input int mode, input logic [7:0] val);
    for (int i = 0; i < 128; i++) msg_b[i] = (mode == 0) ? val : 8'($urandom);
  endtask

  // Starts a message in the current cycle and follows it until back in IDLE.
  task automatic run_msg(input int len_in, input int hold0, input bit rnd_ready);
    int L, nblk, idx, cyc, waited;
    logic rdy;
    L = (len_in > MB) ? MB : len_in;
    build_expected(L);
    nblk = exp_q.size();
    pack_msg();
    msg_len = CW'(len_in);
    beginPreprocess = 1'b1;
    block_ready = 1'b0;
    @(posedge clk); #1;
    beginPreprocess = 1'b0;
    check("load_busy", 512'(busy), 512'd1);
    check("load_valid", 512'(block_valid), 512'd0);
    scramble_inputs();
    beginPreprocess = 1'b1;
    @(posedge clk); #1;
    beginPreprocess = 1'b0;
    idx = 0; cyc = 0; waited = 0;
    while (idx < nblk && cyc < 300) begin
      check("valid", 512'(block_valid), 512'd1);
      check("block", processedMsg, exp_q[idx]);
      check("last", 512'(last_block), 512'(idx == nblk - 1));
      check("emit_busy", 512'(busy), 512'd1);
      check("emit_done", 512'(done), 512'd0);
      if (idx == 0 && waited < hold0) begin
        rdy = 1'b0;
        waited++;
      end else begin
        rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      block_ready = rdy;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    if (cyc >= 300) check("timeout", 512'd0, 512'd1);
    block_ready = 1'b0;
    check("post_valid", 512'(block_valid), 512'd0);
    check("post_last", 512'(last_block), 512'd0);
    check("done_pulse", 512'(done), 512'd1);
    check("done_busy", 512'(busy), 512'd1);
    @(posedge clk); #1;
    check("done_clear", 512'(done), 512'd0);
    check("idle_busy", 512'(busy), 512'd0);
    check("hold_block", processedMsg, exp_q[nblk-1]);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    n_rst = 1'b0;
    inputMsg = '0;
    msg_len = '0;
    beginPreprocess = 1'b0;
    block_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_block", processedMsg, 512'd0);
    check("rst_flags", 512'({block_valid, last_block, busy, done}), 512'd0);
    n_rst = 1'b1;

    fill_msg(0, 8'h00); msg_b[0] = 8'h61;
    run_msg(1, 0, 1'b0);
    fill_msg(0, 8'h41); run_msg(55, 0, 1'b0);
    fill_msg(0, 8'h41); run_msg(56, 0, 1'b0);
    fill_msg(1, 8'h00); run_msg(80, 0, 1'b0);
    fill_msg(0, 8'h41); run_msg(56, 5, 1'b0);
    fill_msg(1, 8'h00); run_msg(0, 0, 1'b0);
    fill_msg(1, 8'h00); run_msg(127, 2, 1'b1);

    // Reset in the middle of emitting block 0 of an 80-byte message.
    fill_msg(1, 8'h00);
    pack_msg();
    msg_len = CW'(80);
    beginPreprocess = 1'b1;
    @(posedge clk); #1;
    beginPreprocess = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 512'(block_valid), 512'd1);
    n_rst = 1'b0;
    block_ready = 1'b1;
    @(posedge clk); #1;
    block_ready = 1'b0;
    check("mid_rst_block", processedMsg, 512'd0);
    check("mid_rst_flags", 512'({block_valid, last_block, busy, done}), 512'd0);
    n_rst = 1'b1;
    fill_msg(0, 8'h00); msg_b[0] = 8'h61;
    run_msg(1, 0, 1'b0);
    fill_msg(1, 8'h00); run_msg(0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      fill_msg(1, 8'h00);
      run_msg($urandom_range(0, 127), $urandom_range(0, 3), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
